// File: rtl/psram_arb_pkg.sv
// Shared types and helpers for the byte-to-burst PSRAM arbiter.
// Lane map: byte offset o within a 64-bit beat sits in lane {o[1:0], o[2]}.
package psram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_HIT,
    WR_BURST,
    RD_WAIT,
    RD_BURST,
    GAP
  } arb_state_t;

  localparam int LINE_BYTES = 32;
  localparam int BEATS      = 4;

  function automatic logic [2:0] lane_of(input logic [2:0] o);
    return {o[1:0], o[2]};
  endfunction

  function automatic logic [7:0] byte_of(input logic [63:0] beat, input logic [2:0] o);
    logic [2:0] l;
    l = lane_of(o);
    return beat[{l, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/psram_line_buf.sv
// Single 32-byte read line buffer: filled one beat at a time from a read burst,
// read a byte at a time, and patched by write-through when a write hits its line.
module psram_line_buf
  import psram_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        inval,
  input  logic        beat_we,
  input  logic [1:0]  beat_idx,
  input  logic [63:0] beat_data,
  input  logic        fill_done,
  input  logic [10:0] fill_tag,
  input  logic        wt_we,
  input  logic [15:0] wt_addr,
  input  logic [7:0]  wt_data,
  input  logic [15:0] rd_addr,
  output logic        rd_hit,
  output logic [7:0]  rd_byte
);
  localparam int OFF_W = $clog2(LINE_BYTES);

  logic [63:0]       mem [BEATS];
  logic [15-OFF_W:0] tag;
  logic              valid;
  logic [2:0]        wt_lane;

  assign wt_lane = lane_of(wt_addr[2:0]);
  assign rd_hit  = valid && (tag == rd_addr[15:OFF_W]);
  assign rd_byte = byte_of(mem[rd_addr[4:3]], rd_addr[2:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      tag   <= '0;
    end else begin
      if (inval)
        valid <= 1'b0;
      if (fill_done) begin
        tag   <= fill_tag;
        valid <= 1'b1;
      end
    end
  end

  // Data array carries no reset; valid gates every use of it.
  always_ff @(posedge clk) begin
    if (beat_we)
      mem[beat_idx] <= beat_data;
    if (wt_we && valid && (tag == wt_addr[15:OFF_W]))
      mem[wt_addr[4:3]][{wt_lane, 3'b000} +: 8] <= wt_data;
  end

endmodule

// File: rtl/psram_byte_arbiter.sv
// Two-port byte arbiter in front of the 64-bit x4 PSRAM burst controller.
//   state    | meaning
//   IDLE     | arbitrate; issue a burst or take a line-buffer hit
//   RD_HIT   | return the buffered byte, no PSRAM access
//   WR_BURST | drive write beats 1..3, ack after beat 3
//   RD_WAIT  | wait for the first read beat or time out
//   RD_BURST | collect read beats 1..3, ack after beat 3
//   GAP      | hold off until the controller recovery gap expires
module psram_byte_arbiter
  import psram_arb_pkg::*;
#(
  parameter int         CMD_GAP    = 14,
  parameter int         RD_TIMEOUT = 64,
  parameter logic [4:0] ADDR_HI    = 5'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_calib,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [7:0]  rdata0,
  output logic [7:0]  rdata1,
  output logic        cmd,
  output logic        cmd_en,
  output logic [20:0] ps_addr,
  output logic [63:0] wr_data,
  output logic [7:0]  data_mask,
  input  logic [63:0] rd_data,
  input  logic        rd_valid,
  output logic        err
);
  localparam int GAP_W = $clog2(CMD_GAP);
  localparam int TO_W  = $clog2(RD_TIMEOUT);

  arb_state_t       state;
  logic             gnt, last_gnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [1:0]       beat_cnt;

  logic        v0, v1, can_grant, sel, sel_we, issue_rd, rd_accept;
  logic [15:0] sel_addr, gnt_addr, lb_addr;
  logic [7:0]  sel_wdata, gnt_wdata, lb_byte, fill_byte;
  logic        lb_hit;

  function automatic logic [7:0] mask_of(input logic [1:0] beat, input logic [4:0] off);
    return (beat == off[4:3]) ? ~(8'h01 << lane_of(off[2:0])) : 8'hFF;
  endfunction

  // A request still high during its own ack cycle is the old one, not a new one.
  always_comb begin
    v0        = req0 & ~ack0;
    v1        = req1 & ~ack1;
    can_grant = init_calib && (gap_cnt == '0) && (v0 || v1);
    sel       = (v0 && v1) ? ~last_gnt : v1;
    sel_we    = sel ? we1 : we0;
    sel_addr  = sel ? addr1 : addr0;
    sel_wdata = sel ? wdata1 : wdata0;
    gnt_addr  = gnt ? addr1 : addr0;
    gnt_wdata = gnt ? wdata1 : wdata0;
    lb_addr   = (state == IDLE) ? sel_addr : gnt_addr;
    issue_rd  = (state == IDLE) && can_grant && !sel_we && !lb_hit;
    rd_accept = rd_valid && ((state == RD_WAIT) || (state == RD_BURST));
    fill_byte = (gnt_addr[4:3] == 2'd3) ? byte_of(rd_data, gnt_addr[2:0]) : lb_byte;
  end

  psram_line_buf u_line_buf (
    .clk       (clk),
    .reset     (reset),
    .inval     (issue_rd),
    .beat_we   (rd_accept),
    .beat_idx  (beat_cnt),
    .beat_data (rd_data),
    .fill_done ((state == RD_BURST) && rd_valid && (beat_cnt == 2'd3)),
    .fill_tag  (gnt_addr[15:5]),
    .wt_we     ((state == WR_BURST) && (beat_cnt == 2'd0)),
    .wt_addr   (gnt_addr),
    .wt_data   (gnt_wdata),
    .rd_addr   (lb_addr),
    .rd_hit    (lb_hit),
    .rd_byte   (lb_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      last_gnt  <= 1'b1;
      gap_cnt   <= '0;
      to_cnt    <= '0;
      beat_cnt  <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= 8'hFF;
      rdata1    <= 8'hFF;
      cmd       <= 1'b0;
      cmd_en    <= 1'b0;
      ps_addr   <= '0;
      wr_data   <= '0;
      data_mask <= 8'hFF;
      err       <= 1'b0;
    end else begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      cmd_en <= 1'b0;
      if (gap_cnt != '0)
        gap_cnt <= gap_cnt - 1'b1;

      case (state)
        IDLE: begin
          if (can_grant) begin
            gnt      <= sel;
            last_gnt <= sel;
            if (!sel_we && lb_hit) begin
              state <= RD_HIT;
            end else begin
              cmd_en   <= 1'b1;
              cmd      <= sel_we;
              ps_addr  <= {ADDR_HI, sel_addr[15:5], 5'h0};
              gap_cnt  <= GAP_W'(CMD_GAP - 1);
              beat_cnt <= 2'd0;
              if (sel_we) begin
                wr_data   <= {8{sel_wdata}};
                data_mask <= mask_of(2'd0, sel_addr[4:0]);
                beat_cnt  <= 2'd1;
                state     <= WR_BURST;
              end else begin
                to_cnt <= TO_W'(RD_TIMEOUT - 1);
                state  <= RD_WAIT;
              end
            end
          end
        end

        RD_HIT: begin
          if (gnt) begin
            ack1   <= 1'b1;
            rdata1 <= lb_byte;
          end else begin
            ack0   <= 1'b1;
            rdata0 <= lb_byte;
          end
          state <= IDLE;
        end

        // beat_cnt wraps to 0 after beat 3, which marks the ack cycle.
        WR_BURST: begin
          if (beat_cnt != 2'd0) begin
            data_mask <= mask_of(beat_cnt, gnt_addr[4:0]);
            beat_cnt  <= beat_cnt + 2'd1;
          end else begin
            data_mask <= 8'hFF;
            if (gnt) ack1 <= 1'b1;
            else     ack0 <= 1'b1;
            state <= GAP;
          end
        end

        RD_WAIT: begin
          if (rd_valid) begin
            beat_cnt <= 2'd1;
            state    <= RD_BURST;
          end else if (to_cnt == '0) begin
            if (gnt) begin
              ack1   <= 1'b1;
              rdata1 <= 8'hFF;
            end else begin
              ack0   <= 1'b1;
              rdata0 <= 8'hFF;
            end
            err   <= 1'b1;
            state <= GAP;
          end else begin
            to_cnt <= to_cnt - 1'b1;
          end
        end

        RD_BURST: begin
          if (rd_valid) begin
            beat_cnt <= beat_cnt + 2'd1;
            if (beat_cnt == 2'd3) begin
              if (gnt) begin
                ack1   <= 1'b1;
                rdata1 <= fill_byte;
              end else begin
                ack0   <= 1'b1;
                rdata0 <= fill_byte;
              end
              state <= GAP;
            end
          end
        end

        GAP: begin
          if (gap_cnt == '0)
            state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_byte_arbiter.sv
// Scoreboard bench for psram_byte_arbiter: stimulus queues expected commands,
// write masks and acks; a negedge monitor pops and compares as the DUT presents them.
module tb_psram_byte_arbiter;

  typedef struct {
    logic       port;
    logic       rd;
    logic [7:0] data;
  } ack_exp_t;

  typedef struct {
    logic        wr;
    logic [20:0] addr;
    logic [63:0] wdata;
  } cmd_exp_t;

  logic        clk;
  logic        reset, init_calib;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        ack0, ack1;
  logic [7:0]  rdata0, rdata1;
  logic        cmd, cmd_en;
  logic [20:0] ps_addr;
  logic [63:0] wr_data;
  logic [7:0]  data_mask;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic        err;

  psram_byte_arbiter dut (
    .clk(clk), .reset(reset), .init_calib(init_calib),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .cmd(cmd), .cmd_en(cmd_en), .ps_addr(ps_addr), .wr_data(wr_data),
    .data_mask(data_mask), .rd_data(rd_data), .rd_valid(rd_valid), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
  endtask

  ack_exp_t   exp_ack[$];
  cmd_exp_t   exp_cmd[$];
  logic [7:0] exp_mask[$];

  task automatic push_ack(input logic port, input logic rd, input logic [7:0] data);
    ack_exp_t e;
    e.port = port; e.rd = rd; e.data = data;
    exp_ack.push_back(e);
  endtask

  task automatic push_cmd(input logic wr, input logic [20:0] a, input logic [7:0] wd);
    cmd_exp_t e;
    e.wr = wr; e.addr = a; e.wdata = {8{wd}};
    exp_cmd.push_back(e);
  endtask

  task automatic push_masks(input logic [7:0] m0, input logic [7:0] m1,
                            input logic [7:0] m2, input logic [7:0] m3);
    exp_mask.push_back(m0); exp_mask.push_back(m1);
    exp_mask.push_back(m2); exp_mask.push_back(m3);
  endtask

  // PSRAM model: answers each read command with four beats after resp_delay cycles.
  logic [63:0] line_mem [4];
  int  resp_delay = 3;
  bit  resp_off = 0;
  int  last_beat_cyc = 0;

  initial begin
    rd_valid = 1'b0;
    rd_data  = '0;
    forever begin
      @(negedge clk);
      if (cmd_en && !cmd && !resp_off) begin
        repeat (resp_delay) @(posedge clk);
        for (int k = 0; k < 4; k++) begin
          #1;
          rd_valid = 1'b1;
          rd_data  = line_mem[k];
          last_beat_cyc = cyc;
          @(posedge clk);
        end
        #1;
        rd_valid = 1'b0;
        rd_data  = '0;
      end
    end
  end

  task automatic set_uniform();
    logic [7:0] b;
    for (int k = 0; k < 4; k++) begin
      b = 8'(17 * (k + 1));
      line_mem[k] = {8{b}};
    end
  endtask

  // Beat k, lane L holds byte {k, L}: 64'h0706050403020100, 64'h17..10, ...
  task automatic set_distinct();
    for (int k = 0; k < 4; k++)
      for (int l = 0; l < 8; l++)
        line_mem[k][8*l +: 8] = {4'(k), 4'(l)};
  endtask

  // Monitor
  int n_cmd = 0;
  int last_cmd_cyc = 0;
  int wr_left = 0;

  initial begin
    ack_exp_t ea;
    cmd_exp_t ec;
    forever begin
      @(negedge clk);
      if (cmd_en) begin
        n_cmd++;
        last_cmd_cyc = cyc;
        if (exp_cmd.size() == 0) begin
          check("cmd_unexpected", 64'(cmd_en), 64'd0);
        end else begin
          ec = exp_cmd.pop_front();
          check("cmd", 64'(cmd), 64'(ec.wr));
          check("ps_addr", 64'(ps_addr), 64'(ec.addr));
          if (ec.wr) check("wr_data", wr_data, ec.wdata);
        end
        if (cmd) wr_left = 4;
      end
      if (wr_left > 0) begin
        wr_left--;
        if (exp_mask.size() == 0) check("mask_q_empty", 64'(exp_mask.size()), 64'd1);
        else check("data_mask", 64'(data_mask), 64'(exp_mask.pop_front()));
      end
      if (ack0 || ack1) begin
        if (exp_ack.size() == 0) begin
          check("ack_unexpected", 64'({ack1, ack0}), 64'd0);
        end else begin
          ea = exp_ack.pop_front();
          check("ack_port", 64'({ack1, ack0}), ea.port ? 64'd2 : 64'd1);
          if (ea.rd) check("rdata", 64'(ea.port ? rdata1 : rdata0), 64'(ea.data));
        end
      end
    end
  end

  task automatic wait_ack(input logic port, input int budget, output int at_c);
    bit got;
    got  = 0;
    at_c = -1;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (port ? ack1 : ack0) begin
        got  = 1;
        at_c = cyc;
      end
    end
    check(port ? "ack1_seen" : "ack0_seen", 64'(got), 64'd1);
  endtask

  task automatic drive_req(input logic port, input logic wr, input logic [15:0] a, input logic [7:0] wd);
    if (port) begin req1 = 1'b1; we1 = wr; addr1 = a; wdata1 = wd; end
    else      begin req0 = 1'b1; we0 = wr; addr0 = a; wdata0 = wd; end
  endtask

  task automatic do_req(input logic port, input logic wr, input logic [15:0] a, input logic [7:0] wd,
                        output int req_c, output int ack_c);
    @(posedge clk); #1;
    drive_req(port, wr, a, wd);
    req_c = cyc;
    wait_ack(port, 200, ack_c);
    @(posedge clk); #1;
    if (port) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "time limit");
  end

  int rc, ac, c1, c2, n0;

  initial begin
    reset = 1'b1; init_calib = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    set_uniform();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 64'({ack1, ack0}), 64'd0);
    check("rst_rdata0", 64'(rdata0), 64'hFF);
    check("rst_rdata1", 64'(rdata1), 64'hFF);
    check("rst_cmd", 64'({cmd, cmd_en}), 64'd0);
    check("rst_ps_addr", 64'(ps_addr), 64'd0);
    check("rst_mask", 64'(data_mask), 64'hFF);
    check("rst_err", 64'(err), 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Read miss, held off while calibration is low
    push_cmd(1'b0, 21'h001220, 8'h00);
    push_ack(1'b0, 1'b1, 8'h33);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 16'h1234, 8'h00);
    idle(6);
    check("calib_block", 64'(n_cmd), 64'd0);
    #1 init_calib = 1'b1;
    wait_ack(1'b0, 200, ac);
    check("miss_ack_after_beat3", 64'(ac - last_beat_cyc), 64'd1);
    @(posedge clk); #1 req0 = 1'b0;
    idle(16);

    // Hit in the same line
    push_ack(1'b0, 1'b1, 8'h33);
    do_req(1'b0, 1'b0, 16'h1235, 8'h00, rc, ac);
    check("hit_latency", 64'(ac - rc), 64'd2);
    idle(4);

    // Lane map: miss with the selected byte in beat 3, then hits in the buffered line
    set_distinct();
    push_cmd(1'b0, 21'h002000, 8'h00);
    push_ack(1'b0, 1'b1, 8'h37);
    do_req(1'b0, 1'b0, 16'h201F, 8'h00, rc, ac);
    idle(16);
    push_ack(1'b0, 1'b1, 8'h23);
    do_req(1'b0, 1'b0, 16'h2015, 8'h00, rc, ac);
    push_ack(1'b0, 1'b1, 8'h00);
    do_req(1'b0, 1'b0, 16'h2000, 8'h00, rc, ac);
    idle(4);

    // Contention: port 0 was granted last, so port 1 goes first
    push_cmd(1'b1, 21'h002000, 8'hC3);
    push_masks(8'hFF, 8'hFF, 8'hF7, 8'hFF);
    push_ack(1'b1, 1'b0, 8'h00);
    push_cmd(1'b1, 21'h002000, 8'h5A);
    push_masks(8'hFD, 8'hFF, 8'hFF, 8'hFF);
    push_ack(1'b0, 1'b0, 8'h00);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, 16'h2004, 8'h5A);
    drive_req(1'b1, 1'b1, 16'h2015, 8'hC3);
    wait_ack(1'b1, 200, ac);
    c1 = last_cmd_cyc;
    check("wr1_ack_lat", 64'(ac - c1), 64'd4);
    @(posedge clk); #1 req1 = 1'b0;
    wait_ack(1'b0, 200, ac);
    c2 = last_cmd_cyc;
    check("wr0_ack_lat", 64'(ac - c2), 64'd4);
    check("cmd_gap_min", 64'((c2 - c1) >= 14), 64'd1);
    @(posedge clk); #1 req0 = 1'b0;
    idle(16);

    // Write-through into the buffered line; neighbour byte untouched
    push_ack(1'b0, 1'b1, 8'hC3);
    do_req(1'b0, 1'b0, 16'h2015, 8'h00, rc, ac);
    push_ack(1'b1, 1'b1, 8'h5A);
    do_req(1'b1, 1'b0, 16'h2004, 8'h00, rc, ac);
    push_ack(1'b0, 1'b1, 8'h03);
    do_req(1'b0, 1'b0, 16'h2005, 8'h00, rc, ac);
    idle(4);

    // Port 1 write outside the buffered line
    push_cmd(1'b1, 21'h000000, 8'hA5);
    push_masks(8'hF7, 8'hFF, 8'hFF, 8'hFF);
    push_ack(1'b1, 1'b0, 8'h00);
    do_req(1'b1, 1'b1, 16'h0005, 8'hA5, rc, ac);
    check("wr_ack_lat", 64'(ac - last_cmd_cyc), 64'd4);
    idle(16);
    push_ack(1'b0, 1'b1, 8'hC3);
    do_req(1'b0, 1'b0, 16'h2015, 8'h00, rc, ac);
    idle(4);

    // Read timeout, then the same line must be fetched again
    resp_off = 1;
    push_cmd(1'b0, 21'h003000, 8'h00);
    push_ack(1'b0, 1'b1, 8'hFF);
    do_req(1'b0, 1'b0, 16'h3000, 8'h00, rc, ac);
    check("timeout_lat", 64'(ac - last_cmd_cyc), 64'd64);
    check("err_set", 64'(err), 64'd1);
    resp_off = 0;
    idle(4);
    push_cmd(1'b0, 21'h003000, 8'h00);
    push_ack(1'b0, 1'b1, 8'h12);
    do_req(1'b0, 1'b0, 16'h3009, 8'h00, rc, ac);
    check("err_sticky", 64'(err), 64'd1);
    idle(16);

    // Reset while waiting for read data; late beats must be ignored
    resp_delay = 8;
    push_cmd(1'b0, 21'h004000, 8'h00);
    n0 = n_cmd;
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 16'h4000, 8'h00);
    for (int i = 0; i < 50 && n_cmd == n0; i++) @(negedge clk);
    check("rst_test_cmd", 64'(n_cmd - n0), 64'd1);
    repeat (2) @(posedge clk);
    #1; reset = 1'b1; req0 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (14) @(negedge clk);
    check("post_rst_ack", 64'({ack1, ack0}), 64'd0);
    check("post_rst_rdata0", 64'(rdata0), 64'hFF);
    check("post_rst_rdata1", 64'(rdata1), 64'hFF);
    check("post_rst_cmd", 64'({cmd, cmd_en}), 64'd0);
    check("post_rst_ps_addr", 64'(ps_addr), 64'd0);
    check("post_rst_mask", 64'(data_mask), 64'hFF);
    check("post_rst_err", 64'(err), 64'd0);
    resp_delay = 3;
    push_cmd(1'b0, 21'h002000, 8'h00);
    push_ack(1'b0, 1'b1, 8'h23);
    do_req(1'b0, 1'b0, 16'h2015, 8'h00, rc, ac);
    idle(20);

    check("ack_q_left", 64'(exp_ack.size()), 64'd0);
    check("cmd_q_left", 64'(exp_cmd.size()), 64'd0);
    check("mask_q_left", 64'(exp_mask.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
